memory_stage: RTL
=================

Name: memory_stage

Overview:
- MEM stage of the 64-bit LEGv8 pipeline, directly downstream of the execute stage.
- Registers EX results into the EX/MEM register and resolves conditional branches (PCSrc).
- Performs data-memory accesses over a req/ack handshake with wait states and a timeout.
- Drives the MEM/WB register consumed by writeback, and stalls upstream while an access is outstanding.

Parameters:
- size, 64: datapath width.
- TIMEOUT, 15: max cycles dm_req may be held without dm_ack before the bus-error abort; counter width $clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_E  input  1  EX output holds a real instruction.
- MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E  input  1 each  control from EX.
- rd_E  input  5  destination register.
- aluResult_E, writeData_E, PCBranch_E  input  size  EX results.
- zero_E  input  1  ALU zero flag.
- flush  input  1  squash the instruction being captured from EX.
- stall_M  output  1  upstream must hold (no advance).
- PCSrc_M  output  1  take branch.
- PCBranch_M  output  size  branch target.
- dm_req, dm_we  output  1  memory request / write enable.
- dm_addr, dm_wdata  output  size  memory address / write data.
- dm_ack  input  1  memory completes this cycle.
- dm_rdata  input  size  read data, valid with dm_ack.
- valid_W, RegWrite_W, MemtoReg_W  output  1  MEM/WB control.
- rd_W  output  5  MEM/WB destination.
- aluResult_W, readData_W  output  size  MEM/WB data.
- bus_err_M, align_err_M  output  1  error flags.

Behaviour:
- Reset: every register and output is 0; FSM is IDLE. Reset mid-access drops dm_req in the following cycle with no write-back.
- EX/MEM capture: when !stall_M, the M register loads all *_E fields. valid_M = valid_E & !flush. When stall_M=1, M holds and flush is ignored.
- memop_M = valid_M & (MemRead_M | MemWrite_M).
- Memory interface (combinational from M):
  - dm_req = memop_M & state!=ERR.
  - dm_we = MemWrite_M.
  - dm_addr = aluResult_M; dm_wdata = writeData_M.
  - dm_req and its fields stay stable until dm_ack.
- stall_M = (dm_req & !dm_ack) | state==ERR.
- Zero-wait access: dm_ack arrives in the same cycle as dm_req, so there is no stall.
- FSM:
  - IDLE -> WAIT when dm_req & !dm_ack; cnt <= 1.
  - WAIT: dm_ack -> IDLE, cnt <= 0. Otherwise, if cnt==TIMEOUT -> ERR; otherwise cnt++.
  - ERR: sticky until reset. dm_req=0, stall_M=1, bus_err_M=1.
  - On the ERR transition, the M instruction retires as a bubble.
- Branch:
  - PCSrc_M = valid_M & Branch_M & zero_M; PCBranch_M = PCBranch_M register.
  - Branches never access memory, so PCSrc_M is a 1-cycle pulse.
  - The controller drives flush from PCSrc_M.
- MEM/WB register, updated every cycle:
  - Retire when valid_M & (!memop_M | dm_ack) & state!=ERR.
  - On retire: valid_W=1, control/rd/aluResult copied from M, readData_W = (MemRead_M & dm_ack) ? dm_rdata : 0.
  - Otherwise: bubble, valid_W=0, RegWrite_W=0, other W fields hold.
- Stores: retire with RegWrite_W as decoded (normally 0).

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - A memop_M with aluResult_M[2:0]!=0 suppresses dm_req and causes no stall.
  - align_err_M=1 for that cycle.
  - The instruction retires as a bubble (valid_W=0).
- MEM_ALIGN_CHECK_EN undefined: align_err_M is tied 0 and addresses pass unchecked.

Test Plan:
- Reset held 2 cycles with valid_E=1 -> all outputs 0, dm_req=0, after release state IDLE.
- LDUR: aluResult_E=0x40, dm_ack in the same cycle with dm_rdata=0xDEAD -> stall_M never 1; next cycle valid_W=1, readData_W=0xDEAD, rd_W preserved.
- STUR: addr=0x80, wdata=0x1234, dm_ack after 3 cycles -> stall_M=1 for 3 cycles, dm_addr/dm_wdata stable, dm_we=1; valid_W=0 during the stall, 1 after.
- CBZ: Branch_E=1, zero_E=1, PCBranch_E=0x100 -> PCSrc_M=1 for exactly one cycle with PCBranch_M=0x100. The same sequence with zero_E=0 gives PCSrc_M=0.
- Load with no dm_ack -> after 15 wait cycles state ERR, bus_err_M=1, dm_req=0, stall_M stuck at 1 until reset, valid_W=0.
- With MEM_ALIGN_CHECK_EN: load at 0x44 -> dm_req=0, align_err_M=1 for one cycle, valid_W=0. Without the macro: dm_req=1 at dm_addr=0x44.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, branch resolve, data-memory handshake, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module memory_stage #(
    parameter int size    = 64,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_E,
    input  logic            MemRead_E,
    input  logic            MemWrite_E,
    input  logic            Branch_E,
    input  logic            RegWrite_E,
    input  logic            MemtoReg_E,
    input  logic [4:0]      rd_E,
    input  logic [size-1:0] aluResult_E,
    input  logic [size-1:0] writeData_E,
    input  logic [size-1:0] PCBranch_E,
    input  logic            zero_E,
    input  logic            flush,
    output logic            stall_M,
    output logic            PCSrc_M,
    output logic [size-1:0] PCBranch_M,
    output logic            dm_req,
    output logic            dm_we,
    output logic [size-1:0] dm_addr,
    output logic [size-1:0] dm_wdata,
    input  logic            dm_ack,
    input  logic [size-1:0] dm_rdata,
    output logic            valid_W,
    output logic            RegWrite_W,
    output logic            MemtoReg_W,
    output logic [4:0]      rd_W,
    output logic [size-1:0] aluResult_W,
    output logic [size-1:0] readData_W,
    output logic            bus_err_M,
    output logic            align_err_M
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;

    logic            valid_M;
    logic            MemRead_M;
    logic            MemWrite_M;
    logic            Branch_M;
    logic            RegWrite_M;
    logic            MemtoReg_M;
    logic            zero_M;
    logic [4:0]      rd_M;
    logic [size-1:0] aluResult_M;
    logic [size-1:0] writeData_M;

    logic memop_M;
    logic misalign;
    logic in_err;
    logic acked;
    logic retire;

    assign memop_M = valid_M & (MemRead_M | MemWrite_M);
    assign in_err  = (state == ERR);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = memop_M & (aluResult_M[2:0] != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    assign align_err_M = misalign;
    assign dm_req      = memop_M & ~misalign & ~in_err;
    assign dm_we       = MemWrite_M;
    assign dm_addr     = aluResult_M;
    assign dm_wdata    = writeData_M;
    assign stall_M     = (dm_req & ~dm_ack) | in_err;
    assign bus_err_M   = in_err;
    assign PCSrc_M     = valid_M & Branch_M & zero_M;

    assign acked  = dm_req & dm_ack;
    assign retire = valid_M & (~memop_M | acked) & ~in_err;

    // EX/MEM pipeline register; holds while the stage is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_M     <= 1'b0;
            MemRead_M   <= 1'b0;
            MemWrite_M  <= 1'b0;
            Branch_M    <= 1'b0;
            RegWrite_M  <= 1'b0;
            MemtoReg_M  <= 1'b0;
            zero_M      <= 1'b0;
            rd_M        <= '0;
            aluResult_M <= '0;
            writeData_M <= '0;
            PCBranch_M  <= '0;
        end else if (!stall_M) begin
            valid_M     <= valid_E & ~flush;
            MemRead_M   <= MemRead_E;
            MemWrite_M  <= MemWrite_E;
            Branch_M    <= Branch_E;
            RegWrite_M  <= RegWrite_E;
            MemtoReg_M  <= MemtoReg_E;
            zero_M      <= zero_E;
            rd_M        <= rd_E;
            aluResult_M <= aluResult_E;
            writeData_M <= writeData_E;
            PCBranch_M  <= PCBranch_E;
        end
    end

    // Wait-state tracker with bus-error timeout; ERR is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dm_req && !dm_ack) begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (dm_ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // MEM/WB register: retire completed instructions, otherwise insert a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_W     <= 1'b0;
            RegWrite_W  <= 1'b0;
            MemtoReg_W  <= 1'b0;
            rd_W        <= '0;
            aluResult_W <= '0;
            readData_W  <= '0;
        end else if (retire) begin
            valid_W     <= 1'b1;
            RegWrite_W  <= RegWrite_M;
            MemtoReg_W  <= MemtoReg_M;
            rd_W        <= rd_M;
            aluResult_W <= aluResult_M;
            readData_W  <= (MemRead_M & acked) ? dm_rdata : '0;
        end else begin
            valid_W    <= 1'b0;
            RegWrite_W <= 1'b0;
        end
    end

endmodule
